matrix_feeder: RTL and testbench

Upstream feeder for the 4x4 systolic matrix multiplier. It buffers one 4x4 weight matrix and one 4x4 activation matrix loaded row by row over a valid/ready port. On `go` it drives the array's four north data inputs plus its `conf`/`start` controls. Weights stream in unskewed during a configure phase, then activations stream in with diagonal skew, column j delayed j cycles.

---
 rtl/matrix_feeder_pkg.sv | 28 ++
 rtl/matrix_feeder_bank.sv | 37 +++
 rtl/matrix_feeder.sv | 155 +++++++++++++++
 tb/tb_matrix_feeder.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_feeder_pkg.sv
// Shared constants and types for the 4x4 systolic-array feeder.
// The element width defaults to the multiplier's data-bus define MM_DATA_W.
`ifndef MM_DATA_W
`define MM_DATA_W 8
`endif

package matrix_feeder_pkg;

  localparam int N          = 4;
  localparam int CONF_CYC   = N;
  localparam int FEED_CYC   = 2 * N - 1;
  localparam int ROW_W      = $clog2(N);
  localparam int DATA_W_DEF = `MM_DATA_W;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CONF  = 3'd1,
    ST_FEED  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef enum logic {
    BANK_W = 1'b0,
    BANK_A = 1'b1
  } bank_t;

endpackage

// File: rtl/matrix_feeder_bank.sv
// feeder_bank: NxN register file with one row write port, one row read port
// and one per-column element read port (each column picks its own row).
module feeder_bank
  import matrix_feeder_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ROW_W-1:0]  wr_row,
  input  logic [N*DATA_W-1:0] wr_data,
  input  logic [ROW_W-1:0]  rd_row,
  output logic [DATA_W-1:0] row_data [N],
  input  logic [ROW_W-1:0]  col_row  [N],
  output logic [DATA_W-1:0] col_data [N]
);

  logic [DATA_W-1:0] mem [N][N];

  // NOTE: storage has no reset; only the row counters and full flags decide
  // what is valid, so resetting the array would only cost flops.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int j = 0; j < N; j++) begin
        mem[wr_row][j] <= wr_data[j*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    for (int j = 0; j < N; j++) begin
      row_data[j] = mem[rd_row][j];
      col_data[j] = mem[col_row[j]][j];
    end
  end

endmodule

// File: rtl/matrix_feeder.sv
// matrix_feeder: buffers a weight and an activation matrix, then streams W
// unskewed (conf) and A diagonally skewed (start). Option: MATRIX_FEEDER_WREUSE_EN.
module matrix_feeder
  import matrix_feeder_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int DRAIN_CYC = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_valid,
  output logic                load_ready,
  input  logic                load_sel,
  input  logic [4*DATA_W-1:0] load_data,
  input  logic                go,
  output logic                busy,
  output logic                done,
  output logic                w_full,
  output logic                a_full,
  output logic [DATA_W-1:0]   data_out0,
  output logic [DATA_W-1:0]   data_out1,
  output logic [DATA_W-1:0]   data_out2,
  output logic [DATA_W-1:0]   data_out3,
  output logic                mm_conf,
  output logic                mm_start
);

  localparam int CNT_MAX = (DRAIN_CYC > FEED_CYC) ? DRAIN_CYC : FEED_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

`ifdef MATRIX_FEEDER_WREUSE_EN
  localparam bit WREUSE = 1'b1;
`else
  localparam bit WREUSE = 1'b0;
`endif

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic [ROW_W-1:0]   w_cnt, a_cnt;
  logic               load_fire, go_ok;
  bank_t              rd_bank;
  logic [CNT_W-1:0]   skew   [N];
  logic [ROW_W-1:0]   col_idx [N];
  logic [DATA_W-1:0]  w_row [N], a_row [N], w_col [N], a_col [N];
  logic [DATA_W-1:0]  data_d [N], data_q [N];

  assign load_ready = (state == ST_IDLE) && !(load_sel ? a_full : w_full);
  assign load_fire  = load_valid && load_ready;
  assign go_ok      = go && (state == ST_IDLE) && w_full && a_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // NOTE: every variable gets its default before the case, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    unique case (state)
      ST_IDLE:  if (go_ok) begin state_d = ST_CONF; cnt_d = '0; end
      ST_CONF:  if (cnt == CNT_W'(CONF_CYC - 1)) begin state_d = ST_FEED; cnt_d = '0; end
                else cnt_d = cnt + 1'b1;
      ST_FEED:  if (cnt == CNT_W'(FEED_CYC - 1)) begin state_d = ST_DRAIN; cnt_d = '0; end
                else cnt_d = cnt + 1'b1;
      ST_DRAIN: if (cnt == CNT_W'(DRAIN_CYC - 1)) begin state_d = ST_DONE; cnt_d = '0; end
                else cnt_d = cnt + 1'b1;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_cnt  <= '0;
      a_cnt  <= '0;
      w_full <= 1'b0;
      a_full <= 1'b0;
    end else begin
      if (load_fire) begin
        if (load_sel == BANK_A) begin
          a_cnt <= a_cnt + 1'b1;
          if (a_cnt == ROW_W'(N - 1)) a_full <= 1'b1;
        end else begin
          w_cnt <= w_cnt + 1'b1;
          if (w_cnt == ROW_W'(N - 1)) w_full <= 1'b1;
        end
      end
      if (state == ST_DONE) begin
        a_full <= 1'b0;
        a_cnt  <= '0;
        if (!WREUSE) begin
          w_full <= 1'b0;
          w_cnt  <= '0;
        end
      end
    end
  end

  feeder_bank #(.DATA_W(DATA_W)) u_w_bank (
    .clk(clk), .wr_en(load_fire && (load_sel == BANK_W)), .wr_row(w_cnt),
    .wr_data(load_data), .rd_row(cnt_d[ROW_W-1:0]), .row_data(w_row),
    .col_row(col_idx), .col_data(w_col)
  );

  feeder_bank #(.DATA_W(DATA_W)) u_a_bank (
    .clk(clk), .wr_en(load_fire && (load_sel == BANK_A)), .wr_row(a_cnt),
    .wr_data(load_data), .rd_row(cnt_d[ROW_W-1:0]), .row_data(a_row),
    .col_row(col_idx), .col_data(a_col)
  );

  // Outputs are registered from the next state, so column j carries A[k-j][j]
  // in FEED cycle k; both banks share indices and the phase picks the bank.
  always_comb begin
    rd_bank = (state_d == ST_FEED) ? BANK_A : BANK_W;
    for (int j = 0; j < N; j++) begin
      skew[j]    = cnt_d - CNT_W'(j);
      col_idx[j] = skew[j][ROW_W-1:0];
      data_d[j]  = '0;
      if (state_d == ST_CONF) begin
        data_d[j] = (rd_bank == BANK_A) ? a_row[j] : w_row[j];
      end else if (state_d == ST_FEED && cnt_d >= CNT_W'(j) && skew[j] < CNT_W'(N)) begin
        data_d[j] = (rd_bank == BANK_A) ? a_col[j] : w_col[j];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      mm_conf  <= 1'b0;
      mm_start <= 1'b0;
      for (int j = 0; j < N; j++) data_q[j] <= '0;
    end else begin
      busy     <= (state_d != ST_IDLE);
      done     <= (state_d == ST_DONE);
      mm_conf  <= (state_d == ST_CONF);
      mm_start <= (state_d == ST_FEED);
      for (int j = 0; j < N; j++) data_q[j] <= data_d[j];
    end
  end

  assign data_out0 = data_q[0];
  assign data_out1 = data_q[1];
  assign data_out2 = data_q[2];
  assign data_out3 = data_q[3];

endmodule

// File: tb/tb_matrix_feeder.sv
// Scoreboard bench for matrix_feeder: a matrix-level model queues the expected
// conf/feed/done beats and a monitor compares them against the DUT every cycle.
module tb_matrix_feeder;

  localparam int DW    = 8;
  localparam int DRAIN = 4;

`ifdef MATRIX_FEEDER_WREUSE_EN
  localparam bit WREUSE = 1'b1;
`else
  localparam bit WREUSE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          load_valid = 1'b0, load_sel = 1'b0, go = 1'b0;
  logic [4*DW-1:0] load_data = '0;
  logic          load_ready, busy, done, w_full, a_full, mm_conf, mm_start;
  logic [DW-1:0] data_out0, data_out1, data_out2, data_out3;

  matrix_feeder #(.DATA_W(DW), .DRAIN_CYC(DRAIN)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_ready(load_ready),
    .load_sel(load_sel), .load_data(load_data), .go(go), .busy(busy), .done(done),
    .w_full(w_full), .a_full(a_full), .data_out0(data_out0), .data_out1(data_out1),
    .data_out2(data_out2), .data_out3(data_out3), .mm_conf(mm_conf), .mm_start(mm_start)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    int            cyc;
    logic          conf;
    logic          start;
    logic          dn;
    logic [4*DW-1:0] data;
  } exp_t;

  exp_t exq[$];

  // Reference model: matrix contents, row counts, full flags, last accepted go edge.
  logic [DW-1:0] mw [4][4];
  logic [DW-1:0] ma [4][4];
  int   mw_cnt = 0, ma_cnt = 0;
  logic mw_full = 1'b0, ma_full = 1'b0;
  int   go_edge = -1000;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(int c, logic cf, logic st, logic dn, logic [4*DW-1:0] d);
    exp_t e;
    e.cyc = c; e.conf = cf; e.start = st; e.dn = dn; e.data = d;
    return e;
  endfunction

  task automatic push_sequence(input int e0);
    logic [4*DW-1:0] d;
    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 4; j++) d[j*DW +: DW] = mw[k][j];
      exq.push_back(mk(e0 + k, 1'b1, 1'b0, 1'b0, d));
    end
    for (int k = 0; k < 7; k++) begin
      d = '0;
      for (int j = 0; j < 4; j++)
        if (k - j >= 0 && k - j <= 3) d[j*DW +: DW] = ma[k-j][j];
      exq.push_back(mk(e0 + 4 + k, 1'b0, 1'b1, 1'b0, d));
    end
    exq.push_back(mk(e0 + 11 + DRAIN, 1'b0, 1'b0, 1'b1, '0));
  endtask

  // One clock of stimulus; starts and ends just after a falling edge.
  task automatic cycle(input logic v, input logic s, input logic [4*DW-1:0] d, input logic g);
    int   e;
    logic bsy, rdy, acc_go;
    e = cyc + 1;
    load_valid = v; load_sel = s; load_data = d; go = g;
    #1;
    bsy    = (e >= go_edge + 1) && (e <= go_edge + 12 + DRAIN);
    rdy    = !bsy && !(s ? ma_full : mw_full);
    acc_go = g && !bsy && mw_full && ma_full;
    check("load_ready", load_ready, rdy);
    @(posedge clk);
    if (e == go_edge + 12 + DRAIN) begin
      ma_full = 1'b0; ma_cnt = 0;
      if (!WREUSE) begin mw_full = 1'b0; mw_cnt = 0; end
    end
    if (v && rdy) begin
      if (s) begin
        for (int j = 0; j < 4; j++) ma[ma_cnt][j] = d[j*DW +: DW];
        ma_cnt++;
        if (ma_cnt == 4) begin ma_cnt = 0; ma_full = 1'b1; end
      end else begin
        for (int j = 0; j < 4; j++) mw[mw_cnt][j] = d[j*DW +: DW];
        mw_cnt++;
        if (mw_cnt == 4) begin mw_cnt = 0; mw_full = 1'b1; end
      end
    end
    if (acc_go) begin
      go_edge = e;
      push_sequence(e);
    end
    @(negedge clk);
    load_valid = 1'b0; go = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ctrl"}, {busy, done, mm_conf, mm_start}, 4'b0000);
    check({tag, "_flags"}, {w_full, a_full}, 2'b00);
    check({tag, "_data"}, {data_out3, data_out2, data_out1, data_out0}, '0);
    check({tag, "_ready"}, load_ready, 1'b1);
  endtask

  // Reset asserted in the middle of the low clock phase.
  task automatic do_reset();
    #2 rst = 1'b0;
    #1 check_reset_values("midreset");
    mw_cnt = 0; ma_cnt = 0; mw_full = 1'b0; ma_full = 1'b0;
    go_edge = -1000;
    exq.delete();
    @(negedge clk);
    rst = 1'b1;
  endtask

  function automatic logic [4*DW-1:0] pattern_row(input int base, input int step);
    logic [4*DW-1:0] d;
    for (int j = 0; j < 4; j++) d[j*DW +: DW] = DW'(base + step * j);
    return d;
  endfunction

  // Monitor: pops one expected beat whenever the DUT drives conf/start/done.
  always @(negedge clk) begin
    if (rst) begin
      check("busy", busy, (cyc >= go_edge) && (cyc <= go_edge + 11 + DRAIN));
      if (mm_conf || mm_start || done) begin
        if (exq.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL unexpected_beat: conf=%0b start=%0b done=%0b with nothing expected (cycle %0d)",
                   mm_conf, mm_start, done, cyc);
        end else begin
          exp_t e;
          e = exq.pop_front();
          check("beat_cycle", cyc, e.cyc);
          check("beat_ctrl", {mm_conf, mm_start, done}, {e.conf, e.start, e.dn});
          check("beat_data", {data_out3, data_out2, data_out1, data_out0}, e.data);
        end
      end else begin
        check("idle_data", {data_out3, data_out2, data_out1, data_out0}, '0);
        if (exq.size() != 0 && exq[0].cyc < cyc) begin
          n_vec++; n_err++;
          $display("FAIL missing_beat: got nothing, expected beat for cycle %0d (cycle %0d)",
                   exq[0].cyc, cyc);
          void'(exq.pop_front());
        end
      end
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    #1 check_reset_values("reset");
    rst = 1'b1;

    // Two weight rows, then reset: the next load must start again at row 0.
    cycle(1'b1, 1'b0, $urandom(), 1'b0);
    cycle(1'b1, 1'b0, $urandom(), 1'b0);
    do_reset();

    // Basic feed with recognisable patterns, backpressure and an ignored go.
    for (int r = 0; r < 4; r++) cycle(1'b1, 1'b0, pattern_row(4 * r + 1, 1), 1'b0);
    cycle(1'b1, 1'b0, $urandom(), 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1);
    idle(2);
    for (int r = 0; r < 4; r++) cycle(1'b1, 1'b1, pattern_row(16 * (r + 1), 1), 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1);
    idle(8);
    cycle(1'b0, 1'b0, '0, 1'b1);
    idle(14);

    // Final activation row and go in the same cycle; a later go runs.
    for (int r = 0; r < 4; r++) cycle(1'b1, 1'b0, $urandom(), 1'b0);
    for (int r = 0; r < 3; r++) cycle(1'b1, 1'b1, $urandom(), 1'b0);
    cycle(1'b1, 1'b1, $urandom(), 1'b1);
    idle(2);
    cycle(1'b0, 1'b0, '0, 1'b1);
    idle(20);

    // Activation-only reload, go, then weight reload and go again.
    for (int r = 0; r < 4; r++) cycle(1'b1, 1'b1, $urandom(), 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1);
    idle(20);
    for (int r = 0; r < 4; r++) cycle(1'b1, 1'b0, $urandom(), 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1);
    idle(20);

    // Random loads and go pulses.
    repeat (300) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom(),
            ($urandom_range(0, 9) == 0));
    end
    idle(20);

    // Reset during FEED abandons the sequence with no done.
    for (int i = 0; i < 16 && !(mw_full && ma_full); i++)
      cycle(1'b1, mw_full, $urandom(), 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b1);
    idle(6);
    do_reset();
    idle(20);

    check("queue_drained", exq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
